// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative RV32M divider: funct3 encodings,
// controller states and the iteration-counter sizing helper.
package mdu_pkg;

    localparam logic [2:0] FN_DIV  = 3'b100;
    localparam logic [2:0] FN_DIVU = 3'b101;
    localparam logic [2:0] FN_REM  = 3'b110;
    localparam logic [2:0] FN_REMU = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PREP = 2'd1,
        ST_ITER = 2'd2,
        ST_DONE = 2'd3
    } div_state_e;

    // Wide enough to hold N itself, not just N-1.
    function automatic int cnt_width(input int xlen, input int unroll);
        return $clog2(xlen / unroll) + 1;
    endfunction

endpackage

// File: rtl/mdu_iter_div_step.sv
// One combinational restoring-division step: shift the next dividend bit into
// the partial remainder and subtract the divisor when it fits.
module div_step #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rem_in,
    input  logic [XLEN-1:0] dividend_in,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] rem_out,
    output logic [XLEN-1:0] dividend_out,
    output logic            q_bit
);

    logic [XLEN:0] shifted;
    logic [XLEN:0] diff;

    // The extra top bit of diff is the borrow: set when the divisor does not fit.
    always_comb begin
        shifted      = {rem_in, dividend_in[XLEN-1]};
        diff         = shifted - {1'b0, divisor};
        q_bit        = ~diff[XLEN];
        rem_out      = q_bit ? diff[XLEN-1:0] : shifted[XLEN-1:0];
        dividend_out = {dividend_in[XLEN-2:0], 1'b0};
    end

endmodule

// File: rtl/mdu_iter_div.sv
// Multi-cycle DIV/DIVU/REM/REMU unit for the execute stage; resolves UNROLL
// quotient bits per cycle and stalls the pipeline while busy.
module mdu_iter_div
    import mdu_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int UNROLL = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            flush,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            div_stall,
    output logic            valid,
    output logic [XLEN-1:0] result
);

    localparam int N_ITER = XLEN / UNROLL;
    localparam int CNT_W  = cnt_width(XLEN, UNROLL);

    div_state_e       state, next_state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       fn;
    logic [XLEN-1:0]  dvd_reg, dvs_reg, rem_reg, quo_reg;
    logic             sign_q, sign_r;
    logic             is_signed, is_rem, div_zero, overflow;
    logic [XLEN-1:0]  dvd_abs, dvs_abs, quo_next, final_res;
    logic [XLEN-1:0]  rem_chain [UNROLL+1];
    logic [XLEN-1:0]  dvd_chain [UNROLL+1];
    logic [UNROLL-1:0] q_bits;

    assign is_signed = (fn == FN_DIV) || (fn == FN_REM);
    assign is_rem    = (fn == FN_REM) || (fn == FN_REMU);
    assign div_zero  = (dvs_reg == '0);
    assign overflow  = is_signed && (dvd_reg == {1'b1, {(XLEN-1){1'b0}}}) && (dvs_reg == '1);
    assign dvd_abs   = (is_signed && dvd_reg[XLEN-1]) ? ('0 - dvd_reg) : dvd_reg;
    assign dvs_abs   = (is_signed && dvs_reg[XLEN-1]) ? ('0 - dvs_reg) : dvs_reg;

    assign rem_chain[0] = rem_reg;
    assign dvd_chain[0] = dvd_reg;

    for (genvar i = 0; i < UNROLL; i++) begin : g_step
        div_step #(.XLEN(XLEN)) u_step (
            .rem_in      (rem_chain[i]),
            .dividend_in (dvd_chain[i]),
            .divisor     (dvs_reg),
            .rem_out     (rem_chain[i+1]),
            .dividend_out(dvd_chain[i+1]),
            .q_bit       (q_bits[UNROLL-1-i])
        );
    end

    // Earliest step in the chain produces the most significant quotient bit.
    always_comb begin
        quo_next  = {quo_reg[XLEN-UNROLL-1:0], q_bits};
        final_res = is_rem ? (sign_r ? ('0 - rem_chain[UNROLL]) : rem_chain[UNROLL])
                           : (sign_q ? ('0 - quo_next) : quo_next);
    end

    always_comb begin
        next_state = state;
        div_stall  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start && !flush) begin
                    next_state = ST_PREP;
                    div_stall  = reset;
                end
            end
            ST_PREP: begin
                div_stall  = 1'b1;
                next_state = (div_zero || overflow) ? ST_DONE : ST_ITER;
            end
            ST_ITER: begin
                div_stall = 1'b1;
                if (cnt == CNT_W'(1)) next_state = ST_DONE;
            end
            ST_DONE: next_state = ST_IDLE;
            default: next_state = ST_IDLE;
        endcase
        if (flush) next_state = ST_IDLE;
    end

    // Result and valid are loaded on entry to DONE so they appear in that cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            fn      <= '0;
            dvd_reg <= '0;
            dvs_reg <= '0;
            rem_reg <= '0;
            quo_reg <= '0;
            sign_q  <= 1'b0;
            sign_r  <= 1'b0;
            valid   <= 1'b0;
            result  <= '0;
        end else begin
            state <= next_state;
            valid <= 1'b0;
            if (flush) begin
                cnt <= '0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (start) begin
                            fn      <= funct3;
                            dvd_reg <= op_a;
                            dvs_reg <= op_b;
                        end
                    end
                    ST_PREP: begin
                        sign_q  <= is_signed & (dvd_reg[XLEN-1] ^ dvs_reg[XLEN-1]);
                        sign_r  <= is_signed & dvd_reg[XLEN-1];
                        dvd_reg <= dvd_abs;
                        dvs_reg <= dvs_abs;
                        rem_reg <= '0;
                        quo_reg <= '0;
                        cnt     <= CNT_W'(N_ITER);
                        if (div_zero) begin
                            result <= is_rem ? dvd_reg : '1;
                            valid  <= 1'b1;
                        end else if (overflow) begin
                            result <= is_rem ? '0 : dvd_reg;
                            valid  <= 1'b1;
                        end
                    end
                    ST_ITER: begin
                        rem_reg <= rem_chain[UNROLL];
                        dvd_reg <= dvd_chain[UNROLL];
                        quo_reg <= quo_next;
                        cnt     <= cnt - CNT_W'(1);
                        if (cnt == CNT_W'(1)) begin
                            result <= final_res;
                            valid  <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
